// File: rtl/pc_rel_pkg.sv
// rtl/pc_rel_pkg.sv - shared types and constants for the PC-relative target generator
//
// Purpose: operation encoding, instruction-alignment selectors and the AUIPC
// shift amount shared by pc_rel_target_gen and its bench.
// Ports: none (package).

package pc_rel_pkg;

  typedef enum logic [1:0] {
    OP_PASS   = 2'b00,
    OP_AUIPC  = 2'b01,
    OP_JAL    = 2'b10,
    OP_BRANCH = 2'b11
  } op_e;

  localparam int IALIGN_16   = 16;
  localparam int IALIGN_32   = 32;
  localparam int AUIPC_SHIFT = 12;

  // Only control-transfer targets are subject to the alignment check.
  function automatic logic is_target_op(input op_e op);
    return (op == OP_JAL) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// rtl/pipe_slice.sv - generic valid/ready register stage with flush
//
// Purpose: one full-throughput pipeline register. Loads whenever it is empty
// or its consumer is taking the current entry; holds data stable otherwise.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop the held entry and any entry offered this cycle
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload

module pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         load;

  assign load      = !valid_q || out_ready;
  assign in_ready  = load;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // Flush wins over an accept offered in the same cycle.
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= in_valid;
      end
      // Data only moves on a real accept so idle outputs keep their last value.
      if (load && in_valid && !flush) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/pc_rel_target_gen.sv
// rtl/pc_rel_target_gen.sv - two-stage pipelined PC-relative address generator
//
// Purpose: computes AUIPC results, JAL/branch targets and the link address
// (pc+4) with a valid/ready handshake, flush, and a saturating counter of
// delivered misaligned targets.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every in-flight entry at the next edge
//   in_valid/in_ready request handshake; in_op/in_pc/in_imm/in_tag request fields
//   out_valid/out_ready result handshake
//   out_result        computed address
//   out_link          in_pc + 4
//   out_misalign      JAL/BRANCH target violates IALIGN
//   out_tag           sideband tag of this result
//   misalign_cnt      saturating count of delivered misaligned results

module pc_rel_target_gen
  import pc_rel_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [XLEN-1:0]  out_link,
  output logic             out_misalign,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] misalign_cnt
);

  localparam int S1_W = 2 + 2 * XLEN + TAG_W;
  localparam int S2_W = 2 * XLEN + 1 + TAG_W;

  // S1: captured request
  logic            s1_valid;
  logic            s1_ready;
  logic [S1_W-1:0] s1_data;

  op_e             s1_op;
  logic [XLEN-1:0] s1_pc;
  logic [XLEN-1:0] s1_imm;
  logic [TAG_W-1:0] s1_tag;

  // Combinational compute between the two stages
  logic [XLEN-1:0] calc_result;
  logic [XLEN-1:0] calc_link;
  logic            calc_misalign;
  logic [S2_W-1:0] calc_data;

  logic [S2_W-1:0] s2_data;

  pipe_slice #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, in_pc, in_imm, in_tag}),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_data)
  );

  assign s1_op  = op_e'(s1_data[S1_W-1 -: 2]);
  assign s1_pc  = s1_data[S1_W-3 -: XLEN];
  assign s1_imm = s1_data[TAG_W+XLEN-1 -: XLEN];
  assign s1_tag = s1_data[TAG_W-1:0];

  always_comb begin
    calc_result   = s1_pc;
    calc_misalign = 1'b0;
    case (s1_op)
      OP_PASS:  calc_result = s1_pc;
      // Shifting within XLEN discards the imm bits that would fall off the top.
      OP_AUIPC: calc_result = s1_pc + (s1_imm << AUIPC_SHIFT);
      default:  calc_result = s1_pc + s1_imm;
    endcase
    if (is_target_op(s1_op)) begin
      if (IALIGN == IALIGN_16) begin
        calc_misalign = calc_result[0];
      end else begin
        calc_misalign = |calc_result[1:0];
      end
    end
  end

  assign calc_link = s1_pc + XLEN'(4);
  assign calc_data = {calc_result, calc_link, calc_misalign, s1_tag};

  pipe_slice #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .in_data   (calc_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_result   = s2_data[S2_W-1 -: XLEN];
  assign out_link     = s2_data[TAG_W+XLEN -: XLEN];
  assign out_misalign = s2_data[TAG_W];
  assign out_tag      = s2_data[TAG_W-1:0];

  // A handshake coinciding with flush still counts: the consumer took it.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_cnt <= '0;
    end else if (out_valid && out_ready && out_misalign && (misalign_cnt != '1)) begin
      misalign_cnt <= misalign_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_rel_target_gen.sv
// tb/tb_pc_rel_target_gen.sv - self-checking bench for pc_rel_target_gen

module tb_pc_rel_target_gen;

  typedef struct {
    logic [31:0] res;
    logic [31:0] link;
    logic        mis;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [3:0]  in_tag;

  logic        in_ready, out_valid, out_misalign;
  logic [31:0] out_result, out_link;
  logic [3:0]  out_tag;
  logic [15:0] misalign_cnt;

  logic        in_ready2, out_valid2, out_misalign2;
  logic [31:0] out_result2, out_link2;
  logic [3:0]  out_tag2;
  logic [1:0]  misalign_cnt2;

  int   tests = 0;
  int   fails = 0;
  int   delivered = 0;
  bit   sb_en = 1'b1;
  exp_t q[$];
  exp_t got_exp;

  always #5 clk = ~clk;

  pc_rel_target_gen #(.XLEN(32), .IALIGN(32), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_pc(in_pc), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_link(out_link), .out_misalign(out_misalign), .out_tag(out_tag),
    .misalign_cnt(misalign_cnt)
  );

  pc_rel_target_gen #(.XLEN(32), .IALIGN(32), .TAG_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
    .in_pc(in_pc), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
    .out_link(out_link2), .out_misalign(out_misalign2), .out_tag(out_tag2),
    .misalign_cnt(misalign_cnt2)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [3:0] tag);
    exp_t e;
    e.tag  = tag;
    e.link = pc + 32'd4;
    case (op)
      2'b00:   e.res = pc;
      2'b01:   e.res = pc + {imm[19:0], 12'h000};
      default: e.res = pc + imm;
    endcase
    e.mis = op[1] ? (e.res[1:0] != 2'b00) : 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [3:0] tag);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_pc    = pc;
    in_imm   = imm;
    in_tag   = tag;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (sb_en && !flush) q.push_back(model(op, pc, imm, tag));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: observed no accept for tag %0d expected accept within 20 cycles", tag);
    end
  endtask

  // Scoreboard: every delivered result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      delivered++;
      tests++;
      assert (q.size() > 0) else begin
        fails++;
        $error("FAIL sb_unexpected: observed tag %0d expected no output", out_tag);
      end
      if (q.size() > 0) begin
        got_exp = q.pop_front();
        chk("sb_result", out_result, got_exp.res);
        chk("sb_link", out_link, got_exp.link);
        chk("sb_misalign", {31'b0, out_misalign}, {31'b0, got_exp.mis});
        chk("sb_tag", {28'b0, out_tag}, {28'b0, got_exp.tag});
      end
    end
  end

  initial begin
    int d0;
    logic [15:0] c0;

    // Reset
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_pc = '0; in_imm = '0; in_tag = '0;
    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_cnt", {16'b0, misalign_cnt}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_tag", {28'b0, out_tag}, 32'd0);
    chk("rst_cnt_sat", {30'b0, misalign_cnt2}, 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // AUIPC with latency check
    send(2'b01, 32'h0000_1000, 32'h0000_0012, 4'd5);
    chk("auipc_lat_early", {31'b0, out_valid}, 32'd0);
    tick();
    chk("auipc_valid", {31'b0, out_valid}, 32'd1);
    chk("auipc_result", out_result, 32'h0001_3000);
    chk("auipc_link", out_link, 32'h0000_1004);
    chk("auipc_misalign", {31'b0, out_misalign}, 32'd0);
    tick();

    // Branch wrap-around
    send(2'b11, 32'hFFFF_FFF0, 32'h0000_0020, 4'd6);
    tick();
    chk("wrap_result", out_result, 32'h0000_0010);
    chk("wrap_link", out_link, 32'hFFFF_FFF4);
    tick();

    // Misaligned branch
    send(2'b11, 32'h0000_0100, 32'h0000_0006, 4'd7);
    tick();
    chk("mis_result", out_result, 32'h0000_0106);
    chk("mis_flag", {31'b0, out_misalign}, 32'd1);
    tick();
    chk("mis_cnt", {16'b0, misalign_cnt}, 32'd1);

    // PASS on an unaligned pc never flags
    send(2'b00, 32'h0000_2002, 32'h0000_DEAD, 4'd8);
    tick();
    chk("pass_result", out_result, 32'h0000_2002);
    chk("pass_misalign", {31'b0, out_misalign}, 32'd0);
    tick();
    chk("pass_cnt", {16'b0, misalign_cnt}, 32'd1);

    // Backward JAL
    send(2'b10, 32'h0000_1000, 32'hFFFF_FFFC, 4'd9);
    tick();
    tick();

    // Backpressure
    d0 = delivered;
    out_ready = 1'b0;
    send(2'b10, 32'h0000_0200, 32'h0000_0010, 4'd1);
    send(2'b10, 32'h0000_0300, 32'h0000_0020, 4'd2);
    in_valid = 1'b1; in_op = 2'b10; in_pc = 32'h0000_0400; in_imm = 32'h0000_0030; in_tag = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_tag", {28'b0, out_tag}, 32'd1);
      chk("bp_hold_result", out_result, 32'h0000_0210);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b10, 32'h0000_0400, 32'h0000_0030, 4'd3);
    send(2'b10, 32'h0000_0500, 32'h0000_0041, 4'd4);
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) tick();
    chk("bp_drained", q.size(), 32'd0);
    chk("bp_delivered", delivered - d0, 32'd4);
    chk("bp_cnt", {16'b0, misalign_cnt}, 32'd2);

    // Flush with both stages full and a request offered
    d0 = delivered;
    c0 = misalign_cnt;
    sb_en = 1'b0;
    out_ready = 1'b0;
    send(2'b10, 32'h0000_0600, 32'h0000_0003, 4'd10);
    send(2'b10, 32'h0000_0700, 32'h0000_0005, 4'd11);
    in_valid = 1'b1; in_op = 2'b10; in_pc = 32'h0000_0800; in_imm = 32'h0000_0001; in_tag = 4'd12;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("flush_delivered", delivered - d0, 32'd0);
    chk("flush_cnt", {16'b0, misalign_cnt}, {16'b0, c0});

    // Flush beats an accept while in_ready is high
    in_valid = 1'b1; in_op = 2'b10; in_pc = 32'h0000_0900; in_imm = 32'h0000_0001; in_tag = 4'd13;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_high", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    chk("flush_accept_dropped", delivered - d0, 32'd0);
    chk("flush_idle", {31'b0, out_valid}, 32'd0);
    sb_en = 1'b1;

    // Counter saturation (CNT_W=2 instance)
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(2'b10, 32'h0000_0800 + 32'(i * 16), 32'h0000_0001, 4'(i));
      tick();
      tick();
      chk("sat_cnt2", {30'b0, misalign_cnt2}, (i < 3) ? 32'(i) : 32'd3);
      chk("sat_cnt16", {16'b0, misalign_cnt}, 32'(i));
    end
    chk("final_queue_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
